// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and bundle-size helper for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} fetch_state_t;

    function automatic int unsigned bundle_bytes(input int unsigned isize);
        return isize / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous bundle FIFO with push/pop/flush; flush beats push and pop
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i/data_i  write an entry (ignored when full and not popping)
//   pop_i          remove the head entry (ignored when empty)
//   flush_i        empty the FIFO
//   head_o         head entry, count_o occupancy
module fetch_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the I-MMU fetch handshake and buffers returned bundles for decode
//   clk, rst_n                         clock, asynchronous active-low reset
//   redirect, redirectPc               restart fetch at (aligned) redirectPc
//   fetchAddress, doFetch, doneFetch   MMU request/completion handshake
//   fetchInstruction                   bundle returned with doneFetch
//   bundleValid, bundle, bundlePc      FIFO head towards decode
//   bundleReady                        decode accepts head
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          INSTRUCTIONSIZE = 128,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [63:0]                redirectPc,
    output logic [63:0]                fetchAddress,
    output logic                       doFetch,
    input  logic                       doneFetch,
    input  logic [INSTRUCTIONSIZE-1:0] fetchInstruction,
    output logic                       bundleValid,
    output logic [INSTRUCTIONSIZE-1:0] bundle,
    output logic [63:0]                bundlePc,
    input  logic                       bundleReady
);
    localparam logic [63:0] STEP  = 64'(bundle_bytes(INSTRUCTIONSIZE));
    localparam logic [63:0] ALIGN = ~(STEP - 64'd1);
    localparam int          CW    = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d, pend_q, pend_d;
    logic [63:0]  target;
    logic [CW-1:0] count, cnt_after;
    logic         push, pop;
    logic [INSTRUCTIONSIZE+63:0] head;

    assign target    = redirectPc & ALIGN;
    assign pop       = bundleValid && bundleReady;
    // Only reached from FETCH, where count < FIFO_DEPTH always holds, so no overflow here.
    assign cnt_after = count + CW'(1) - CW'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (count != CW'(FIFO_DEPTH)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect && doneFetch) begin
                    pc_d = target;
                end else if (redirect) begin
                    // The MMU request cannot be cancelled; keep driving it and drop its data.
                    pend_d  = target;
                    state_d = DISCARD;
                end else if (doneFetch) begin
                    push    = 1'b1;
                    pc_d    = pc_q + STEP;
                    state_d = cnt_after < CW'(FIFO_DEPTH) ? FETCH : IDLE;
                end
            end
            DISCARD: begin
                if (doneFetch) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    fetch_fifo #(
        .WIDTH(INSTRUCTIONSIZE + 64),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({fetchInstruction, pc_q}),
        .pop_i   (pop),
        .flush_i (redirect),
        .head_o  (head),
        .count_o (count)
    );

    assign doFetch      = state_q != IDLE;
    assign fetchAddress = pc_q;
    assign bundleValid  = count != '0;
    assign bundle       = bundleValid ? head[INSTRUCTIONSIZE+63:64] : '0;
    assign bundlePc     = bundleValid ? head[63:0] : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random MMU/decode/redirect traffic checked by a queue-based reference model
module tb_fetch_sequencer;
    localparam int IS = 128;
    localparam int D  = 4;

    logic          clk = 1'b0, rst_n = 1'b0, redirect = 1'b0, doneFetch = 1'b0, bundleReady = 1'b0;
    logic [63:0]   redirectPc = '0;
    logic [IS-1:0] fetchInstruction = '0;
    logic          doFetch, bundleValid;
    logic [63:0]   fetchAddress, bundlePc;
    logic [IS-1:0] bundle;

    always #5 clk = ~clk;

    fetch_sequencer #(.INSTRUCTIONSIZE(IS), .FIFO_DEPTH(D), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirectPc(redirectPc),
        .fetchAddress(fetchAddress), .doFetch(doFetch), .doneFetch(doneFetch),
        .fetchInstruction(fetchInstruction), .bundleValid(bundleValid), .bundle(bundle),
        .bundlePc(bundlePc), .bundleReady(bundleReady)
    );

    int tests = 0, fails = 0;

    typedef struct {
        logic [63:0]   pc;
        logic [IS-1:0] data;
    } ent_t;

    ent_t        q[$];
    logic [63:0] exp_addr = '0, req_addr = '0;
    bit          req_active = 0, discarding = 0;
    int          idle_cnt = 0, pops = 0, sz = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rst_check();
        chk("rst_doFetch", doFetch, 1'b0);
        chk("rst_fetchAddress", fetchAddress, 64'h0);
        chk("rst_bundleValid", bundleValid, 1'b0);
        chk("rst_bundle", bundle, '0);
        chk("rst_bundlePc", bundlePc, 64'h0);
    endtask

    // Reference model: every kept MMU return becomes the next expected bundle in order;
    // a redirect empties the expectation and poisons any return already outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_addr   = 64'h0;
            req_active = 0;
            discarding = 0;
            idle_cnt   = 0;
        end else begin
            sz = q.size();
            if (doFetch && !req_active) begin
                chk("req_addr", fetchAddress, exp_addr);
                chk("req_has_slot", sz < D, 1'b1);
                req_active = 1;
                req_addr   = fetchAddress;
            end else if (doFetch) begin
                chk("addr_stable", fetchAddress, req_addr);
            end
            chk("bundle_valid", bundleValid, sz != 0);
            if (bundleValid && bundleReady && !redirect && sz != 0) begin
                chk("bundle_pc", bundlePc, q[0].pc);
                chk("bundle_data", bundle, q[0].data);
                void'(q.pop_front());
                pops++;
            end
            if (doneFetch && req_active) begin
                req_active = 0;
                if (!discarding && !redirect) begin
                    q.push_back('{req_addr, fetchInstruction});
                    exp_addr = req_addr + 64'd16;
                end
                discarding = 0;
            end
            if (redirect) begin
                q.delete();
                exp_addr = redirectPc & ~64'hF;
                if (req_active) discarding = 1;
            end
            if (!doFetch && sz < D) begin
                idle_cnt++;
                chk("no_stall", idle_cnt <= 1, 1'b1);
            end else begin
                idle_cnt = 0;
            end
        end
    end

    bit busy = 0;
    int cnt = 0;

    initial begin
        #1 rst_check();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            doneFetch = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    doneFetch        = 1'b1;
                    fetchInstruction = {$urandom, $urandom, $urandom, $urandom};
                    busy             = 0;
                end else begin
                    cnt--;
                end
            end else if (doFetch) begin
                busy = 1;
                cnt  = $urandom_range(0, 2);
            end else if ($urandom_range(0, 9) == 0) begin
                doneFetch        = 1'b1;
                fetchInstruction = {$urandom, $urandom, $urandom, $urandom};
            end
            redirect   = c > 200 && $urandom_range(0, 19) == 0;
            redirectPc = $urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(0, 63))
                                                   : {32'h0, $urandom};
            bundleReady = (c / 64) % 3 == 1 ? 1'b0 : $urandom_range(0, 3) != 0;
            if (c == 1500 || c == 3000) begin
                #2 rst_n = 1'b0;
                #1 rst_check();
                redirect  = 1'b0;
                doneFetch = 1'b0;
                busy      = 0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        chk("enough_bundles", pops > 200, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
